// File: rtl/add128_seq.sv
// 128-bit adder that reuses one 32-bit CLA slice over four cycles, LSB slice first.
// Optional subtraction (a - b) is compiled in when ADD128_SUB_EN is defined.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = ci;

    // 4-bit lookahead groups; group carries ripple between groups
    for (genvar k = 0; k < 8; k++) begin : grp
        logic [3:0] gg;
        logic [3:0] pp;
        logic [4:0] cc;
        assign gg    = g[4*k +: 4];
        assign pp    = p[4*k +: 4];
        assign cc[0] = gc[k];
        assign cc[1] = gg[0] | (pp[0] & cc[0]);
        assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
        assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & cc[0]);
        assign cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0])
                     | (pp[3] & pp[2] & pp[1] & pp[0] & cc[0]);
        assign c[4*k +: 4] = cc[3:0];
        assign gc[k+1]     = cc[4];
    end

    assign s  = p ^ c;
    assign co = gc[8];
endmodule

module add128_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         ci,
`ifdef ADD128_SUB_EN
    input  logic         op,
`endif
    output logic [127:0] s,
    output logic         co,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t       state;
    state_t       state_nx;
    logic [1:0]   cnt;
    logic [127:0] a_r;
    logic [127:0] b_r;
    logic         c_r;
    logic [31:0]  sl_sum;
    logic         sl_co;
    logic [6:0]   base;
    logic         accept;
    logic         last;
    logic [127:0] b_in;
    logic         c_in;

    assign base   = {cnt, 5'b0};
    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == 2'd3);

`ifdef ADD128_SUB_EN
    // two's-complement subtract: invert b and force the carry-in
    assign b_in = op ? ~b : b;
    assign c_in = op ? 1'b1 : ci;
`else
    assign b_in = b;
    assign c_in = ci;
`endif

    cla32 u_slice (
        .a  (a_r[base +: 32]),
        .b  (b_r[base +: 32]),
        .ci (c_r),
        .s  (sl_sum),
        .co (sl_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == 2'd3) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            a_r  <= '0;
            b_r  <= '0;
            c_r  <= 1'b0;
            s    <= '0;
            co   <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_r <= a;
                b_r <= b_in;
                c_r <= c_in;
                cnt <= 2'd0;
            end else if (state == RUN) begin
                s[base +: 32] <= sl_sum;
                c_r           <= sl_co;
                cnt           <= cnt + 2'd1;
                if (cnt == 2'd3) co <= sl_co;
            end
        end
    end
endmodule

// File: tb/tb_add128_seq.sv
// Directed self-checking bench for add128_seq; subtraction vectors run when ADD128_SUB_EN is defined.
module tb_add128_seq;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] a;
    logic [127:0] b;
    logic         ci;
`ifdef ADD128_SUB_EN
    logic         op;
`endif
    logic [127:0] s;
    logic         co;
    logic         busy;
    logic         done;

    int errors;
    int checks;

    add128_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef ADD128_SUB_EN
        .op    (op),
`endif
        .s     (s),
        .co    (co),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // accept at E0, expect busy through E3, done and result at E4, done gone at E5
    task automatic run_op(input string tag, input logic [127:0] va, input logic [127:0] vb,
                          input logic vci, input logic [127:0] es, input logic eco);
        a = va; b = vb; ci = vci; start = 1'b1;
        step();
        start = 1'b0;
        a = ~va; b = ~vb; ci = ~vci;
        chk({tag, "_busy0"}, {127'd0, busy}, 128'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk({tag, "_busyrun"}, {126'd0, busy, done}, 128'd2);
        end
        step();
        chk({tag, "_done"}, {126'd0, busy, done}, 128'd1);
        chk({tag, "_s"}, s, es);
        chk({tag, "_co"}, {127'd0, co}, {127'd0, eco});
        step();
        chk({tag, "_done_gone"}, {127'd0, done}, 128'd0);
        chk({tag, "_s_hold"}, s, es);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; start = 1'b1; a = '1; b = 128'd1; ci = 1'b0;
`ifdef ADD128_SUB_EN
        op = 1'b0;
`endif
        step();
        step();
        chk("rst_s", s, 128'd0);
        chk("rst_flags", {125'd0, co, busy, done}, 128'd0);
        rst = 1'b0; start = 1'b0;
        step();
        chk("rst_no_busy", {127'd0, busy}, 128'd0);

        run_op("ripple", '1, 128'd1, 1'b0, 128'd0, 1'b1);
        run_op("slice32", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
               128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);
        run_op("cin_only", 128'd0, 128'd0, 1'b1, 128'd1, 1'b0);
        run_op("mixed", 128'h0123456789abcdef_fedcba9876543210,
               128'h1111111111111111_1111111111111111, 1'b0,
               128'h123456789abcdf01_0fedcba987654321, 1'b0);
        run_op("msb_carry", 128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 128'd1, 1'b1);

        // start held through RUN with other operands: one done, first result, re-accept at E5
        a = 128'd100; b = 128'd23; ci = 1'b0; start = 1'b1;
        step();
        a = '1; b = '1; ci = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("prot_no_done", {127'd0, done}, 128'd0);
        end
        step();
        chk("prot_done", {127'd0, done}, 128'd1);
        chk("prot_s", s, 128'd123);
        chk("prot_co", {127'd0, co}, 128'd0);
        step();
        start = 1'b0;
        chk("prot_reaccept", {126'd0, busy, done}, 128'd2);
        for (int i = 1; i < 4; i++) step();
        step();
        chk("prot2_done", {127'd0, done}, 128'd1);
        chk("prot2_s", s, '1);
        chk("prot2_co", {127'd0, co}, 128'd1);
        step();

        // abort: reset lands at E2
        a = 128'd9; b = 128'd9; ci = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_idle", {126'd0, busy, done}, 128'd0);
        chk("abort_s", s, 128'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_done", {126'd0, busy, done}, 128'd0);
        end
        run_op("after_abort", 128'd40, 128'd2, 1'b0, 128'd42, 1'b0);

`ifdef ADD128_SUB_EN
        op = 1'b1;
        run_op("sub_neg", 128'd5, 128'd7, 1'b0, ~128'd1, 1'b0);
        run_op("sub_pos", 128'd7, 128'd5, 1'b0, 128'd2, 1'b1);
        op = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
